// File: rtl/key_boundary_scan.sv
// key_boundary_scan: column-major edge scan that latches the first column holding WHITE_COUNT / BLACK_COUNT rising-edge clusters.
// Optional macro KEY_SCAN_EARLY_EXIT_EN: stop the scan as soon as both colours have matched.
module key_boundary_scan #(
    parameter int H_PIXELS     = 320,
    parameter int V_PIXELS     = 180,
    parameter int MAX_CLUSTERS = 4,
    parameter int MARGIN       = 6,
    parameter int READ_LATENCY = 2,
    parameter int WHITE_COUNT  = 2,
    parameter int BLACK_COUNT  = 3,
    parameter int X_W          = $clog2(H_PIXELS),
    parameter int Y_W          = $clog2(V_PIXELS),
    parameter int A_W          = $clog2(H_PIXELS * V_PIXELS)
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        start_in,
    input  logic                        pixel_from_fb,
    output logic [A_W-1:0]              addr_into_fb,
    output logic                        busy_out,
    output logic                        done_out,
    output logic                        white_valid_out,
    output logic                        black_valid_out,
    output logic [X_W-1:0]              white_x_out,
    output logic [X_W-1:0]              black_x_out,
    output logic [MAX_CLUSTERS*Y_W-1:0] white_y_out,
    output logic [MAX_CLUSTERS*Y_W-1:0] black_y_out
);
    localparam int C_W = $clog2(MAX_CLUSTERS + 2);
    localparam int RL = READ_LATENCY;
    localparam logic [Y_W-1:0] Y_END = Y_W'(V_PIXELS - 1);
    localparam logic [X_W-1:0] X_END = X_W'(H_PIXELS - 1);
    localparam logic [Y_W:0] Y_LO = (Y_W+1)'(MARGIN);
    localparam logic [Y_W:0] Y_HI = (Y_W+1)'(V_PIXELS - MARGIN);
    localparam logic [A_W-1:0] V_A = A_W'(V_PIXELS);
    localparam logic [C_W-1:0] C_SAT = C_W'(MAX_CLUSTERS + 1);
    localparam logic [C_W-1:0] C_MAX = C_W'(MAX_CLUSTERS);
    localparam logic [C_W-1:0] C_WHITE = C_W'(WHITE_COUNT);
    localparam logic [C_W-1:0] C_BLACK = C_W'(BLACK_COUNT);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

    state_t                    state_q;
    logic [X_W-1:0]            ix_q;
    logic [Y_W-1:0]            iy_q;
    logic [RL:0]               v_p_q;
    logic [RL:0]               f_p_q;
    logic [X_W-1:0]            x_p_q [RL+1];
    logic [Y_W-1:0]            y_p_q [RL+1];
    logic                      prev_q;
    logic [C_W-1:0]            cnt_q;
    logic [C_W-1:0]            cnt_d;
    logic [MAX_CLUSTERS*Y_W-1:0] slots_q;
    logic [MAX_CLUSTERS*Y_W-1:0] slots_d;
    logic                      ev;
    logic [X_W-1:0]            ex;
    logic [Y_W-1:0]            ey;
    logic                      rise;
    logic                      col_end;
    logic                      last_px;
    logic                      w_hit;
    logic                      b_hit;
    logic                      early_stop;

    assign ev = v_p_q[RL];
    assign ex = x_p_q[RL];
    assign ey = y_p_q[RL];
    // the first row of each column sees a virtual 1 above it, so edges never span columns
    assign rise = ev && !(f_p_q[RL] | prev_q) && pixel_from_fb
                  && ({1'b0, ey} >= Y_LO) && ({1'b0, ey} < Y_HI);
    assign cnt_d = (rise && cnt_q != C_SAT) ? cnt_q + 1'b1 : cnt_q;
    assign col_end = ev && ey == Y_END;
    assign last_px = col_end && ex == X_END;
    assign w_hit = col_end && !white_valid_out && cnt_d == C_WHITE && cnt_d <= C_MAX;
    assign b_hit = col_end && !black_valid_out && cnt_d == C_BLACK && cnt_d <= C_MAX;
`ifdef KEY_SCAN_EARLY_EXIT_EN
    assign early_stop = white_valid_out && black_valid_out;
`else
    assign early_stop = 1'b0;
`endif

    always_comb begin
        slots_d = slots_q;
        for (int i = 0; i < MAX_CLUSTERS; i++)
            if (rise && cnt_q == C_W'(i)) slots_d[i*Y_W +: Y_W] = ey;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q         <= IDLE;
            ix_q            <= '0;
            iy_q            <= '0;
            v_p_q           <= '0;
            f_p_q           <= '0;
            for (int k = 0; k <= RL; k++) begin
                x_p_q[k] <= '0;
                y_p_q[k] <= '0;
            end
            prev_q          <= 1'b0;
            cnt_q           <= '0;
            slots_q         <= '0;
            addr_into_fb    <= '0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
            white_valid_out <= 1'b0;
            black_valid_out <= 1'b0;
            white_x_out     <= '0;
            black_x_out     <= '0;
            white_y_out     <= '0;
            black_y_out     <= '0;
        end else begin
            v_p_q <= {v_p_q[RL-1:0], 1'b0};
            f_p_q <= {f_p_q[RL-1:0], 1'b0};
            for (int k = 1; k <= RL; k++) begin
                x_p_q[k] <= x_p_q[k-1];
                y_p_q[k] <= y_p_q[k-1];
            end
            if (ev) prev_q <= pixel_from_fb;
            cnt_q   <= col_end ? '0 : cnt_d;
            slots_q <= col_end ? '0 : slots_d;
            if (w_hit) begin
                white_valid_out <= 1'b1;
                white_x_out     <= ex;
                white_y_out     <= slots_d;
            end
            if (b_hit) begin
                black_valid_out <= 1'b1;
                black_x_out     <= ex;
                black_y_out     <= slots_d;
            end
            case (state_q)
                IDLE: if (start_in) begin
                    state_q         <= SCAN;
                    busy_out        <= 1'b1;
                    ix_q            <= '0;
                    iy_q            <= '0;
                    v_p_q           <= '0;
                    cnt_q           <= '0;
                    slots_q         <= '0;
                    white_valid_out <= 1'b0;
                    black_valid_out <= 1'b0;
                    white_x_out     <= '0;
                    black_x_out     <= '0;
                    white_y_out     <= '0;
                    black_y_out     <= '0;
                end
                SCAN: if (early_stop) begin
                    state_q  <= DONE;
                    busy_out <= 1'b0;
                    done_out <= 1'b1;
                    v_p_q    <= '0;
                end else begin
                    addr_into_fb <= A_W'(iy_q) + A_W'(ix_q) * V_A;
                    v_p_q[0]     <= 1'b1;
                    f_p_q[0]     <= iy_q == '0;
                    x_p_q[0]     <= ix_q;
                    y_p_q[0]     <= iy_q;
                    iy_q         <= iy_q == Y_END ? '0 : iy_q + 1'b1;
                    if (iy_q == Y_END) ix_q <= ix_q + 1'b1;
                    if (iy_q == Y_END && ix_q == X_END) state_q <= FLUSH;
                end
                FLUSH: if (early_stop || last_px) begin
                    state_q  <= DONE;
                    busy_out <= 1'b0;
                    done_out <= 1'b1;
                    v_p_q    <= '0;
                end
                DONE: begin
                    state_q  <= IDLE;
                    done_out <= 1'b0;
                end
            endcase
        end
    end
endmodule
